cpu_mem_slave: RTL and testbench

- Memory-side slave that sits directly downstream of the multi-cycle RISC-V core's native valid/ready memory bus.
- Serves instruction fetches, loads and stores from an internal word-addressed RAM with programmable wait states.
- Decodes a small MMIO window for testbench/host control: done flag, scratch, cycle counter.
- Keeps per-class access counters and a sticky bus-error flag for PIM performance debug.

---
 rtl/cpu_mem_slave.sv | 157 +++++++++++++++
 tb/tb_cpu_mem_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_slave.sv
// Memory-side slave for the RISC-V core's valid/ready bus: word RAM with programmable
// wait states, a small MMIO window (done flag, scratch, cycle counter) and access counters.
module cpu_mem_slave #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] done_code,
    output logic        bus_err,
    output logic [31:0] cnt_fetch,
    output logic [31:0] cnt_load,
    output logic [31:0] cnt_store
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_CNT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    logic [31:0] ram [MEM_WORDS];
    logic [31:0] scratch, cycle_cnt, rdata_q, read_word;
    logic [AW-1:0] ram_idx;
    logic [1:0]  mmio_off;
    logic        in_ram, in_mmio, is_write, accept;

    // Power-up image of the RAM; the contents are deliberately not touched by reset.
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ram[i] = '0;
    end

    assign accept = (state == IDLE) && mem_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mem_valid) state_next = (LAT_CNT != 4'd0) ? WAIT : RESP;
            WAIT: if (wait_cnt <= 4'd1) state_next = RESP;
            RESP: state_next = HOLD;
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request copy and wait counter are always reloaded on acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            wstrb_q  <= mem_wstrb;
            instr_q  <= mem_instr;
            wait_cnt <= LAT_CNT;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign in_ram   = {1'b0, addr_q} < RAM_BYTES;
    assign in_mmio  = addr_q[31:4] == MMIO_BASE[31:4];
    assign mmio_off = addr_q[3:2];
    assign ram_idx  = addr_q[AW+1:2];
    assign is_write = |wstrb_q;

    always_comb begin
        read_word = 32'hDEAD_BEEF;
        if (in_ram) begin
            read_word = ram[ram_idx];
        end else if (in_mmio) begin
            case (mmio_off)
                2'd0:    read_word = {31'b0, done};
                2'd1:    read_word = scratch;
                2'd2:    read_word = cycle_cnt;
                default: read_word = 32'h0;
            endcase
        end
    end

    assign mem_ready = (state == RESP);
    // Read data is live during the response cycle (pre-write word on stores) and held afterwards.
    assign mem_rdata = mem_ready ? read_word : rdata_q;

    // NOTE: the RAM array has no reset branch; reset only gates the write enable.
    always_ff @(posedge clk) begin
        if (!reset && mem_ready && is_write && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) ram[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            done      <= 1'b0;
            done_code <= '0;
            bus_err   <= 1'b0;
            scratch   <= '0;
            cycle_cnt <= '0;
            cnt_fetch <= '0;
            cnt_load  <= '0;
            cnt_store <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (mem_ready) begin
                rdata_q <= read_word;
                if (is_write)     cnt_store <= cnt_store + 32'd1;
                else if (instr_q) cnt_fetch <= cnt_fetch + 32'd1;
                else              cnt_load  <= cnt_load + 32'd1;

                if (!in_ram && !in_mmio) bus_err <= 1'b1;

                if (!in_ram && in_mmio && is_write) begin
                    case (mmio_off)
                        2'd0: begin
                            // Only the first completion code is kept until reset.
                            if (!done) begin
                                done      <= 1'b1;
                                done_code <= wdata_q;
                            end
                        end
                        2'd1: begin
                            for (int i = 0; i < 4; i++) begin
                                if (wstrb_q[i]) scratch[8*i +: 8] <= wdata_q[8*i +: 8];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_slave.sv
// Directed bench for cpu_mem_slave: one instance at LATENCY=1 for the main traffic and
// one at LATENCY=3 for the reset-abort case.
module tb_cpu_mem_slave;

    localparam logic [31:0] MMIO = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_valid, a_instr, a_ready, a_done, a_bus_err;
    logic [31:0] a_addr, a_wdata, a_rdata, a_done_code, a_cnt_fetch, a_cnt_load, a_cnt_store;
    logic [3:0]  a_wstrb;

    logic        b_reset, b_valid, b_instr, b_ready, b_done, b_bus_err;
    logic [31:0] b_addr, b_wdata, b_rdata, b_done_code, b_cnt_fetch, b_cnt_load, b_cnt_store;
    logic [3:0]  b_wstrb;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu_mem_slave #(.MEM_WORDS(1024), .LATENCY(1), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .reset(a_reset), .mem_valid(a_valid), .mem_instr(a_instr),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
        .mem_ready(a_ready), .mem_rdata(a_rdata), .done(a_done), .done_code(a_done_code),
        .bus_err(a_bus_err), .cnt_fetch(a_cnt_fetch), .cnt_load(a_cnt_load), .cnt_store(a_cnt_store)
    );

    cpu_mem_slave #(.MEM_WORDS(1024), .LATENCY(3), .MMIO_BASE(MMIO)) dut3 (
        .clk(clk), .reset(b_reset), .mem_valid(b_valid), .mem_instr(b_instr),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
        .mem_ready(b_ready), .mem_rdata(b_rdata), .done(b_done), .done_code(b_done_code),
        .bus_err(b_bus_err), .cnt_fetch(b_cnt_fetch), .cnt_load(b_cnt_load), .cnt_store(b_cnt_store)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input logic v, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (b) begin
            b_valid = v; b_instr = instr; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
        end else begin
            a_valid = v; a_instr = instr; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
        end
    endtask

    function automatic logic rdy(input bit b);
        return b ? b_ready : a_ready;
    endfunction

    // One complete transaction raised in an IDLE cycle; lat = cycles from raise to ready.
    task automatic access(input bit b, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr,
                          output logic [31:0] rdata, output int lat);
        drive(b, 1'b1, instr, addr, wdata, wstrb);
        step();
        lat = 1;
        while (!rdy(b) && lat < 40) begin
            step();
            lat++;
        end
        rdata = b ? b_rdata : a_rdata;
        drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        int lat;

        a_reset = 1'b1;
        b_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) step();
        check("rst_ready", {31'b0, a_ready}, 32'h0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_done", {31'b0, a_done}, 32'h0);
        check("rst_done_code", a_done_code, 32'h0);
        check("rst_bus_err", {31'b0, a_bus_err}, 32'h0);
        check("rst_cnt_fetch", a_cnt_fetch, 32'h0);
        check("rst_cnt_load", a_cnt_load, 32'h0);
        check("rst_cnt_store", a_cnt_store, 32'h0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        step();

        // Seed RAM[0] with an instruction word.
        access(1'b0, 32'h0, 32'h0000_0093, 4'hF, 1'b0, rd, lat);
        check("seed_lat", 32'(lat), 32'd2);

        // Fetch timing: valid in cycle T, ready only in T+2, low again in T+3.
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
        check("fetch_T0_ready", {31'b0, a_ready}, 32'h0);
        step();
        check("fetch_T1_ready", {31'b0, a_ready}, 32'h0);
        step();
        check("fetch_T2_ready", {31'b0, a_ready}, 32'h1);
        check("fetch_rdata", a_rdata, 32'h0000_0093);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        check("fetch_T3_ready", {31'b0, a_ready}, 32'h0);
        check("fetch_cnt", a_cnt_fetch, 32'd1);
        check("fetch_rdata_hold", a_rdata, 32'h0000_0093);
        step();

        // Byte-strobed store; the store returns the pre-write word.
        access(1'b0, 32'h40, 32'h1122_3344, 4'hF, 1'b0, rd, lat);
        access(1'b0, 32'h40, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat);
        check("store_prewrite", rd, 32'h1122_3344);
        access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, lat);
        check("merge_rdata", rd, 32'h11BB_33DD);
        check("merge_lat", 32'(lat), 32'd2);
        check("merge_cnt_store", a_cnt_store, 32'd3);
        check("merge_cnt_load", a_cnt_load, 32'd1);

        // Core keeps valid high through the HOLD cycle: exactly one response.
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        step();
        step();
        check("held_ready", {31'b0, a_ready}, 32'h1);
        step();
        check("held_hold_ready", {31'b0, a_ready}, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("held_idle_ready", {31'b0, a_ready}, 32'h0);
        step();
        check("held_after1_ready", {31'b0, a_ready}, 32'h0);
        step();
        check("held_after2_ready", {31'b0, a_ready}, 32'h0);
        check("held_cnt_load", a_cnt_load, 32'd2);
        access(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, lat);
        check("next_fetch_rdata", rd, 32'h0000_0093);
        check("next_fetch_lat", 32'(lat), 32'd2);
        check("next_fetch_cnt", a_cnt_fetch, 32'd2);

        // Out-of-range load, then sticky error through a good access.
        access(1'b0, 32'h0800_0000, 32'h0, 4'h0, 1'b0, rd, lat);
        check("oor_rdata", rd, 32'hDEAD_BEEF);
        check("oor_lat", 32'(lat), 32'd2);
        check("oor_bus_err", {31'b0, a_bus_err}, 32'h1);
        access(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, lat);
        check("good_after_err_rdata", rd, 32'h11BB_33DD);
        check("bus_err_sticky", {31'b0, a_bus_err}, 32'h1);
        check("cnt_load_after_err", a_cnt_load, 32'd4);
        check("cnt_store_after_err", a_cnt_store, 32'd3);

        // Scratch register with byte strobes.
        access(1'b0, MMIO + 32'h4, 32'h1234_5678, 4'hF, 1'b0, rd, lat);
        access(1'b0, MMIO + 32'h4, 32'h0000_FF00, 4'b0010, 1'b0, rd, lat);
        access(1'b0, MMIO + 32'h4, 32'h0, 4'h0, 1'b0, rd, lat);
        check("scratch_rdata", rd, 32'h1234_FF78);

        // Last RAM word is in range; the next word address is not.
        access(1'b0, 32'hFFC, 32'h5A5A_A5A5, 4'hF, 1'b0, rd, lat);
        access(1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, rd, lat);
        check("ram_top_rdata", rd, 32'h5A5A_A5A5);
        access(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, rd, lat);
        check("ram_past_top_rdata", rd, 32'hDEAD_BEEF);

        // Done flag keeps the first code.
        access(1'b0, MMIO, 32'h1, 4'hF, 1'b0, rd, lat);
        access(1'b0, MMIO, 32'h2, 4'hF, 1'b0, rd, lat);
        check("done_flag", {31'b0, a_done}, 32'h1);
        check("done_code_first", a_done_code, 32'h1);
        access(1'b0, MMIO, 32'h0, 4'h0, 1'b0, rd, lat);
        check("done_readback", rd, 32'h1);

        // Cycle counter: back-to-back reads are four cycles apart at LATENCY=1.
        access(1'b0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c1, lat);
        access(1'b0, MMIO + 32'h8, 32'h0, 4'h0, 1'b0, c2, lat);
        check("cycle_grows", {31'b0, c2 > c1}, 32'h1);
        check("cycle_delta", c2 - c1, 32'd4);
        access(1'b0, MMIO + 32'hC, 32'h0, 4'h0, 1'b0, rd, lat);
        check("mmio_c_rdata", rd, 32'h0);
        check("final_cnt_store", a_cnt_store, 32'd8);
        check("final_cnt_load", a_cnt_load, 32'd11);
        check("final_cnt_fetch", a_cnt_fetch, 32'd2);

        // LATENCY=3 instance: reset in the cycle after acceptance aborts the store.
        access(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat);
        check("l3_seed_lat", 32'(lat), 32'd4);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        step();
        b_reset = 1'b1;
        check("l3_abort_ready_wait", {31'b0, b_ready}, 32'h0);
        step();
        b_reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("l3_abort_cnt_store", b_cnt_store, 32'h0);
        check("l3_abort_rdata", b_rdata, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check("l3_abort_no_ready", {31'b0, b_ready}, 32'h0);
            step();
        end
        access(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, rd, lat);
        check("l3_ram_unchanged", rd, 32'hCAFE_F00D);
        check("l3_fresh_lat", 32'(lat), 32'd4);
        check("l3_cnt_store", b_cnt_store, 32'h0);
        check("l3_cnt_load", b_cnt_load, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
